// File: rtl/slice_step_controller.sv
// slice_step_controller: sequences one step unit over all z-slices via a read/compute/write-back pipeline
// Ports: clk, rst (async, active-high); start (level step request); done (1-cycle completion pulse);
//   busy (READ/FLUSH); mem_rd_en/mem_rd_addr (RAM read, data valid next cycle); ld_reg (datapath load);
//   mem_wr_en/mem_wr_addr (RAM write-back); stall (pipeline freeze, only when SLICE_STALL_EN is defined).
module slice_step_controller #(
  parameter int NUM_SLICES = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef SLICE_STALL_EN
  input  logic              stall,
`endif
  output logic              done,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              ld_reg,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr
);
  typedef enum logic [2:0] {IDLE, ARM, READ, FLUSH, FIN} state_t;
  localparam logic [ADDR_W-1:0] last_addr = ADDR_W'(NUM_SLICES - 1);
  state_t state;
  logic [ADDR_W-1:0] rd_cnt, a1, a2;
  logic v1, v2, fl, hold;
  assign busy = state == READ || state == FLUSH;
`ifdef SLICE_STALL_EN
  assign hold = stall && busy;
`else
  assign hold = 1'b0;
`endif
  assign done = state == FIN;
  assign mem_rd_en = state == READ && !hold;
  assign mem_rd_addr = rd_cnt;
  assign ld_reg = v1 && !hold;
  assign mem_wr_en = v2 && !hold;
  assign mem_wr_addr = a2;
  // fl marks the second FLUSH cycle: it is set only when the previous cycle was already FLUSH
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_cnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
      fl <= 1'b0;
    end else if (!hold) begin
      v1 <= state == READ;
      a1 <= rd_cnt;
      v2 <= v1;
      a2 <= a1;
      fl <= state == FLUSH;
      case (state)
        IDLE: state <= start ? ARM : IDLE;
        ARM: state <= start ? ARM : READ;
        READ: begin
          rd_cnt <= rd_cnt == last_addr ? '0 : rd_cnt + ADDR_W'(1);
          state <= rd_cnt == last_addr ? FLUSH : READ;
        end
        FLUSH: state <= fl ? FIN : FLUSH;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_slice_step_controller.sv
// tb_slice_step_controller: table-driven and randomized checks of slice_step_controller against a progress-count model
module tb_slice_step_controller;
`ifdef SLICE_STALL_EN
  localparam bit has_stall = 1'b1;
`else
  localparam bit has_stall = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0, sel = 1'b0;
  always #5 clk = ~clk;
  logic d0, b0, r0, l0, w0, d1, b1, r1, l1, w1;
  logic [5:0] ra0, wa0;
  logic [0:0] ra1, wa1;
  slice_step_controller #(.NUM_SLICES(64), .ADDR_W(6)) dut0 (
    .clk(clk), .rst(rst), .start(start & ~sel),
`ifdef SLICE_STALL_EN
    .stall(stall & ~sel),
`endif
    .done(d0), .busy(b0), .mem_rd_en(r0), .mem_rd_addr(ra0), .ld_reg(l0), .mem_wr_en(w0), .mem_wr_addr(wa0));
  slice_step_controller #(.NUM_SLICES(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel),
`ifdef SLICE_STALL_EN
    .stall(stall & sel),
`endif
    .done(d1), .busy(b1), .mem_rd_en(r1), .mem_rd_addr(ra1), .ld_reg(l1), .mem_wr_en(w1), .mem_wr_addr(wa1));
  logic o_done, o_busy, o_rd, o_ld, o_wr;
  logic [5:0] o_ra, o_wa;
  assign o_done = sel ? d1 : d0;
  assign o_busy = sel ? b1 : b0;
  assign o_rd = sel ? r1 : r0;
  assign o_ld = sel ? l1 : l0;
  assign o_wr = sel ? w1 : w0;
  assign o_ra = sel ? {5'b0, ra1} : ra0;
  assign o_wa = sel ? {5'b0, wa1} : wa0;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_done"}, int'(o_done), 0);
    chk({nm, "_busy"}, int'(o_busy), 0);
    chk({nm, "_rd"}, int'(o_rd), 0);
    chk({nm, "_ld"}, int'(o_ld), 0);
    chk({nm, "_wr"}, int'(o_wr), 0);
    chk({nm, "_rdaddr"}, int'(o_ra), 0);
    chk({nm, "_wraddr"}, int'(o_wa), 0);
  endtask
  typedef struct {
    int s; int hold; int pulse; int st_at; int st_len; int rst_at; int rearm; int rnd; int exp_lat; int exp_wr;
  } vec_t;
  vec_t tab[$];
  // Model: p counts non-stalled busy cycles since ARM exit; slice i is read at p=i, loaded at p=i+1,
  // written at p=i+2, and done appears at p=n+2.
  task automatic run_step(input vec_t v, output int lat, output int nwr);
    int n, p, sc;
    bit s, fs;
    n = v.s != 0 ? 1 : 64;
    p = 0;
    sc = 0;
    lat = -1;
    nwr = 0;
    for (int i = 0; i <= v.hold; i++) begin
      @(posedge clk);
      #1;
      sel = v.s[0];
      start = i < v.hold;
      stall = has_stall && $urandom_range(0, 1) == 1;
      @(negedge clk);
      chk("pre_busy", int'(o_busy), 0);
      chk("pre_rd", int'(o_rd), 0);
      chk("pre_done", int'(o_done), 0);
      if (i == 0) chk("idle_rdaddr", int'(o_ra), 0);
    end
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      fs = p == v.st_at && sc < v.st_len;
      s = has_stall && p < n + 2 && (fs || (v.rnd != 0 && $urandom_range(0, 3) == 0));
      if (s && fs) sc++;
      stall = s || (has_stall && v.rnd != 0 && p == n + 2 && $urandom_range(0, 1) == 1);
      start = p == v.pulse || (v.rnd != 0 && p < n + 2 && $urandom_range(0, 7) == 0) || (v.rearm != 0 && p == n + 2);
      @(negedge clk);
      if (p == n + 2) begin
        chk("fin_done", int'(o_done), 1);
        chk("fin_busy", int'(o_busy), 0);
        chk("fin_rd", int'(o_rd), 0);
        chk("fin_ld", int'(o_ld), 0);
        chk("fin_wr", int'(o_wr), 0);
        lat = c;
        break;
      end
      chk("busy", int'(o_busy), 1);
      chk("done", int'(o_done), 0);
      chk("rd_en", int'(o_rd), int'(!s && p < n));
      chk("ld", int'(o_ld), int'(!s && p >= 1 && p <= n));
      chk("wr_en", int'(o_wr), int'(!s && p >= 2 && p <= n + 1));
      if (p < n) chk("rd_addr", int'(o_ra), p);
      if (!s && p >= 2 && p <= n + 1) chk("wr_addr", int'(o_wa), p - 2);
      if (o_wr) nwr++;
      if (p == v.rst_at) begin
        rst = 1'b1;
        #1;
        chk_zero("rst_now");
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          chk("post_rst_done", int'(o_done), 0);
          chk("post_rst_wr", int'(o_wr), 0);
          chk("post_rst_busy", int'(o_busy), 0);
        end
        return;
      end
      if (!s) p++;
    end
    if (lat < 0) chk("step_timeout", lat, n + 3);
    if (v.rearm != 0) begin
      @(posedge clk);
      #1;
      stall = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("rearm_idle_busy", int'(o_busy), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("rearm_arm_rd", int'(o_rd), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rearm_read", int'(o_rd), 1);
      chk("rearm_addr", int'(o_ra), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask
  initial begin
    int lat, nwr, rs;
    #1 rst = 1'b1;
    #2;
    sel = 1'b0;
    #1 chk_zero("reset64");
    sel = 1'b1;
    #1 chk_zero("reset1");
    sel = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tab.push_back('{0, 2, -1, -1, 0, -1, 0, 0, 67, 64});
    tab.push_back('{0, 10, 20, -1, 0, -1, 0, 0, 67, 64});
    tab.push_back('{0, 2, -1, -1, 0, 30, 0, 0, -1, 29});
    tab.push_back('{0, 2, -1, -1, 0, -1, 0, 0, 67, 64});
    tab.push_back('{1, 2, -1, -1, 0, -1, 0, 0, 4, 1});
    tab.push_back('{1, 1, -1, -1, 0, -1, 1, 0, 4, 1});
    tab.push_back('{0, 3, -1, -1, 0, -1, 1, 0, 67, 64});
    tab.push_back('{1, 2, -1, -1, 0, 0, 0, 0, -1, 0});
`ifdef SLICE_STALL_EN
    tab.push_back('{0, 2, -1, 10, 5, -1, 0, 0, 72, 64});
    tab.push_back('{1, 2, -1, 0, 3, -1, 0, 0, 7, 1});
`endif
    for (int i = 0; i < 8; i++) begin
      rs = int'($urandom_range(0, 1));
      tab.push_back('{rs, int'($urandom_range(1, 4)), -1, -1, 0, -1, 0, 1, -2, rs != 0 ? 1 : 64});
    end
    foreach (tab[i]) begin
      run_step(tab[i], lat, nwr);
      if (tab[i].exp_lat != -2) chk($sformatf("latency[%0d]", i), lat, tab[i].exp_lat);
      chk($sformatf("writes[%0d]", i), nwr, tab[i].exp_wr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
